// File: rtl/trig_pulse_ctrl_pkg.sv
// Shared types for the trigger pulse controller: FSM state encoding and
// the timer width helper used by the top and the timer sub-module.
package trig_pulse_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_REARM   = 2'd3
    } state_e;

    // Bits needed to hold max(pulse_len, holdoff_len)-1; never less than one.
    function automatic int tmr_width(input int pulse_len, input int holdoff_len);
        int m;
        m = (pulse_len > holdoff_len) ? pulse_len : holdoff_len;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/trig_pulse_ctrl_timer.sv
// Loadable down-counter that stops at zero and reports when it is there.
module trig_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/trig_pulse_ctrl.sv
// One-shot pulse generator on rising edges of a qualified trigger, with
// retrigger holdoff, release rearm, saturating event count and overrun flag.
module trig_pulse_ctrl
    import trig_pulse_ctrl_pkg::*;
#(
    parameter int PULSE_LEN   = 8,
    parameter int HOLDOFF_LEN = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trigger,
    input  logic             clr_cnt,
    output logic             pulse,
    output logic             busy,
    output logic [CNT_W-1:0] event_cnt,
    output logic             overrun
);

    localparam int TW = tmr_width(PULSE_LEN, HOLDOFF_LEN);
    localparam logic [TW-1:0] PULSE_LOAD   = TW'(PULSE_LEN - 1);
    localparam logic [TW-1:0] HOLDOFF_LOAD = TW'(HOLDOFF_LEN - 1);

    state_e           state_q, state_d;
    logic             trig_d_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_base;
    logic             ovr_q, ovr_d;
    logic             rise;
    logic             accept;
    logic             overrun_edge;
    logic             tmr_load;
    logic [TW-1:0]    tmr_load_val;
    logic             tmr_zero;

    trig_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .zero_o     (tmr_zero)
    );

    assign rise         = trigger & ~trig_d_q;
    assign overrun_edge = rise & (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        accept       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d      = ST_PULSE;
                    tmr_load     = 1'b1;
                    tmr_load_val = PULSE_LOAD;
                    accept       = 1'b1;
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    state_d      = ST_HOLDOFF;
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLDOFF_LOAD;
                end
            end
            ST_HOLDOFF: begin
                if (tmr_zero) begin
                    state_d = trigger ? ST_REARM : ST_IDLE;
                end
            end
            ST_REARM: begin
                if (!trigger) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear is applied before the increment so a coincident event reads 1.
    always_comb begin
        cnt_base = clr_cnt ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (accept && (cnt_base != '1)) begin
            cnt_d = cnt_base + CNT_W'(1);
        end
        ovr_d = ovr_q;
        if (overrun_edge) begin
            ovr_d = 1'b1;
        end else if (clr_cnt) begin
            ovr_d = 1'b0;
        end
    end

    // trig_d resets high so a trigger already asserted at release is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            trig_d_q <= 1'b1;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trig_d_q <= trigger;
            pulse_q  <= (state_d == ST_PULSE);
            cnt_q    <= cnt_d;
            ovr_q    <= ovr_d;
        end
    end

    assign pulse     = pulse_q;
    assign busy      = (state_q != ST_IDLE);
    assign event_cnt = cnt_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_trig_pulse_ctrl.sv
// Scoreboarded bench for trig_pulse_ctrl (PULSE_LEN=4, HOLDOFF_LEN=6, CNT_W=2).
module tb_trig_pulse_ctrl;

    localparam int PL = 4;
    localparam int HL = 6;
    localparam int CW = 2;

    typedef struct {
        int start;
        int cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          trigger = 1'b0;
    logic          clr_cnt = 1'b0;
    logic          pulse;
    logic          busy;
    logic [CW-1:0] event_cnt;
    logic          overrun;

    int   n_err = 0;
    int   n_chk = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    exp_t e;
    bit   in_pulse = 1'b0;
    int   start_cyc = 0;
    int   start_cnt = 0;

    trig_pulse_ctrl #(
        .PULSE_LEN   (PL),
        .HOLDOFF_LEN (HL),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trigger   (trigger),
        .clr_cnt   (clr_cnt),
        .pulse     (pulse),
        .busy      (busy),
        .event_cnt (event_cnt),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: measures every completed pulse against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            in_pulse = 1'b0;
        end else if (pulse && !in_pulse) begin
            in_pulse  = 1'b1;
            start_cyc = cyc;
            start_cnt = int'(event_cnt);
        end else if (!pulse && in_pulse) begin
            in_pulse = 1'b0;
            n_chk++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL pulse_unexpected: got pulse at cycle %0d, required none", start_cyc);
            end else begin
                e = sb_q.pop_front();
                $display("pulse start=%0d width=%0d cnt=%0d (exp start=%0d cnt=%0d)",
                         start_cyc, cyc - start_cyc, start_cnt, e.start, e.cnt);
                if (start_cyc !== e.start) begin
                    n_err++;
                    $display("FAIL pulse_start: got %0d required %0d", start_cyc, e.start);
                end
                n_chk++;
                if ((cyc - start_cyc) !== PL) begin
                    n_err++;
                    $display("FAIL pulse_width: got %0d required %0d", cyc - start_cyc, PL);
                end
                n_chk++;
                if (start_cnt !== e.cnt) begin
                    n_err++;
                    $display("FAIL pulse_cnt: got %0d required %0d", start_cnt, e.cnt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int cnt);
        exp_t x;
        x.start = cyc + 1;
        x.cnt   = cnt;
        sb_q.push_back(x);
    endtask

    task automatic do_reset(input logic trig_lvl);
        rst_n   = 1'b0;
        trigger = trig_lvl;
        clr_cnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        n_chk++; if (pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse: got %b required 0", pulse); end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_chk++; if (event_cnt !== 2'd0) begin n_err++; $display("FAIL reset_cnt: got %0d required 0", event_cnt); end
        n_chk++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b required 0", overrun); end
    endtask

    task automatic test_held();
        trigger = 1'b1;
        push_exp(1);
        tick();
        n_chk++; if (pulse !== 1'b1) begin n_err++; $display("FAIL held_pulse_latency: got %b required 1", pulse); end
        n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL held_busy_latency: got %b required 1", busy); end
        for (int i = 1; i < 20; i++) begin
            tick();
            if (i == 3) begin
                n_chk++; if (pulse !== 1'b1) begin n_err++; $display("FAIL held_pulse_last: got %b required 1", pulse); end
            end
            if (i == 4) begin
                n_chk++; if (pulse !== 1'b0 || busy !== 1'b1) begin
                    n_err++; $display("FAIL held_holdoff: got pulse=%b busy=%b required pulse=0 busy=1", pulse, busy);
                end
            end
        end
        n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL held_rearm_busy: got %b required 1", busy); end
        trigger = 1'b0;
        tick();
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL held_release_busy: got %b required 0", busy); end
        n_chk++; if (event_cnt !== 2'd1) begin n_err++; $display("FAIL held_cnt: got %0d required 1", event_cnt); end
        n_chk++; if (overrun !== 1'b0) begin n_err++; $display("FAIL held_overrun: got %b required 0", overrun); end
    endtask

    task automatic test_overrun();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        n_chk++; if (event_cnt !== 2'd0) begin n_err++; $display("FAIL ovr_clr: got %0d required 0", event_cnt); end
        trigger = 1'b1;
        push_exp(1);
        tick();
        trigger = 1'b0;
        tick();
        tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        n_chk++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b required 1", overrun); end
        n_chk++; if (pulse !== 1'b1) begin n_err++; $display("FAIL ovr_pulse_kept: got %b required 1", pulse); end
        repeat (8) tick();
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovr_idle: got busy=%b required 0", busy); end
        n_chk++; if (event_cnt !== 2'd1) begin n_err++; $display("FAIL ovr_cnt: got %0d required 1", event_cnt); end
    endtask

    task automatic test_reset_held();
        do_reset(1'b1);
        repeat (5) tick();
        n_chk++; if (pulse !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL held_reset_quiet: got pulse=%b busy=%b required 0 0", pulse, busy);
        end
        n_chk++; if (event_cnt !== 2'd0) begin n_err++; $display("FAIL held_reset_cnt: got %0d required 0", event_cnt); end
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        push_exp(1);
        tick();
        n_chk++; if (pulse !== 1'b1) begin n_err++; $display("FAIL held_reset_rise: got %b required 1", pulse); end
        n_chk++; if (event_cnt !== 2'd1) begin n_err++; $display("FAIL held_reset_rise_cnt: got %0d required 1", event_cnt); end
        trigger = 1'b0;
        repeat (12) tick();
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL held_reset_idle: got %b required 0", busy); end
    endtask

    task automatic test_saturate();
        int exp_cnt;
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        for (int ev = 1; ev <= 5; ev++) begin
            exp_cnt = (ev > 3) ? 3 : ev;
            trigger = 1'b1;
            push_exp(exp_cnt);
            tick();
            trigger = 1'b0;
            repeat (11) tick();
            n_chk++;
            if (int'(event_cnt) !== exp_cnt) begin
                n_err++; $display("FAIL sat_cnt[%0d]: got %0d required %0d", ev, event_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_clr_coincident();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        trigger = 1'b1;
        push_exp(1);
        tick();
        trigger = 1'b0;
        repeat (11) tick();
        trigger = 1'b1;
        push_exp(2);
        tick();
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        repeat (10) tick();
        n_chk++; if (event_cnt !== 2'd2 || overrun !== 1'b1) begin
            n_err++; $display("FAIL clr_setup: got cnt=%0d ovr=%b required 2 1", event_cnt, overrun);
        end
        trigger = 1'b1;
        clr_cnt = 1'b1;
        push_exp(1);
        tick();
        n_chk++; if (event_cnt !== 2'd1) begin n_err++; $display("FAIL clr_accept_cnt: got %0d required 1", event_cnt); end
        n_chk++; if (overrun !== 1'b0) begin n_err++; $display("FAIL clr_accept_ovr: got %b required 0", overrun); end
        trigger = 1'b0;
        clr_cnt = 1'b0;
        tick();
        trigger = 1'b1;
        clr_cnt = 1'b1;
        tick();
        n_chk++; if (overrun !== 1'b1) begin n_err++; $display("FAIL clr_ovr_set_wins: got %b required 1", overrun); end
        n_chk++; if (event_cnt !== 2'd0) begin n_err++; $display("FAIL clr_ovr_cnt: got %0d required 0", event_cnt); end
        trigger = 1'b0;
        clr_cnt = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_async_reset();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        n_chk++; if (pulse !== 1'b1 || event_cnt !== 2'd1) begin
            n_err++; $display("FAIL arst_pre: got pulse=%b cnt=%0d required 1 1", pulse, event_cnt);
        end
        rst_n = 1'b0;
        #1;
        n_chk++; if (pulse !== 1'b0) begin n_err++; $display("FAIL arst_pulse: got %b required 0", pulse); end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b required 0", busy); end
        n_chk++; if (event_cnt !== 2'd0) begin n_err++; $display("FAIL arst_cnt: got %0d required 0", event_cnt); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_idle: got %b required 0", busy); end
        trigger = 1'b1;
        push_exp(1);
        tick();
        n_chk++; if (pulse !== 1'b1) begin n_err++; $display("FAIL arst_new_event: got %b required 1", pulse); end
        trigger = 1'b0;
        repeat (12) tick();
        n_chk++; if (event_cnt !== 2'd1) begin n_err++; $display("FAIL arst_new_cnt: got %0d required 1", event_cnt); end
    endtask

    initial begin
        test_reset();
        test_held();
        test_overrun();
        test_reset_held();
        test_saturate();
        test_clr_coincident();
        test_async_reset();
        tick();
        n_chk++;
        if (sb_q.size() != 0) begin
            n_err++; $display("FAIL sb_drain: got %0d pending pulses required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/trig_pulse_ctrl.md
# trig_pulse_ctrl

Downstream consumer of the hold-qualified `trigger` produced by the sustained-enable detector. Detects each rising edge of `trigger` and emits one fixed-width output pulse. After the pulse it enforces a retrigger holdoff and then waits for `trigger` to release. It also counts accepted events and flags edges that arrive while it is busy.

## Interface
- PULSE_LEN, default 8: output pulse width in clk cycles, must be ≥1.
- HOLDOFF_LEN, default 16: lockout cycles after the pulse, must be ≥1.
- CNT_W, default 8: width of the event counter.
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- trigger  in  1  registered level from the detector stage, synchronous to clk.
- clr_cnt  in  1  synchronous clear of `event_cnt` and `overrun`.
- pulse  out  1  registered one-shot output.
- busy  out  1  high whenever the state is not IDLE.
- event_cnt  out  CNT_W  accepted-event count; saturates at all-ones.
- overrun  out  1  sticky flag: a rising edge arrived while busy.

## Operation
- `trig_d` holds `trigger` delayed by one cycle. `rise = trigger & ~trig_d`.
- FSM states: IDLE, PULSE, HOLDOFF, REARM. A down-counter `tmr` of width clog2(max(PULSE_LEN,HOLDOFF_LEN)) times the PULSE and HOLDOFF states.
- IDLE: on `rise` go to PULSE, load `tmr=PULSE_LEN-1`, and increment `event_cnt` unless it is saturated.
- PULSE: while `tmr!=0`, decrement it. At `tmr==0`, go to HOLDOFF and load `tmr=HOLDOFF_LEN-1`.
- HOLDOFF: while `tmr!=0`, decrement it. At `tmr==0`, go to IDLE if `trigger==0`, otherwise go to REARM.
- REARM: go to IDLE on the first cycle that `trigger==0`.
- A `rise` in any state other than IDLE is not counted and does not restart the timer. It sets `overrun`.
- `pulse` is a register that is high exactly while the state is PULSE. `busy` is decoded from the state register, so it is glitch-free.
- When `clr_cnt` and an accepted event occur in the same cycle, `event_cnt` becomes 1 (clear first, then increment).
- When `clr_cnt` and an overrun edge occur in the same cycle, `overrun` becomes 1 (set wins).
- Saturated `event_cnt` holds at all-ones until `clr_cnt`.

## Timing
- Reset values: state=IDLE, `tmr`=0, `pulse`=0, `busy`=0, `event_cnt`=0, `overrun`=0, `trig_d`=1.
  - `trig_d` resets to 1 so that a `trigger` already high at reset release is not counted. `trigger` must fall first.
- Latency: `trigger` sampled high at edge k (with `trig_d=0`) makes `pulse` and `busy` high after edge k.
- `pulse` stays high for exactly PULSE_LEN cycles and falls after edge k+PULSE_LEN.
- HOLDOFF lasts exactly HOLDOFF_LEN cycles.
  - Earliest next accepted rise: edge k+PULSE_LEN+HOLDOFF_LEN+1, which requires `trigger` to fall during holdoff.
  - If `trigger` is held high through holdoff, the state stays in REARM. A new event then needs `trigger` to fall and rise again.
- Asserting `rst_n` low mid-pulse or mid-holdoff drops `pulse` and `busy` immediately (asynchronously). No partial state is retained.

## Structure
- Shared package holds the state encoding enum (IDLE=0, PULSE=1, HOLDOFF=2, REARM=3) and a clog2-based timer-width function.
- Sub-module `trig_timer` is a loadable down-counter with a `zero` flag, parameterised by width. The FSM and counters stay in the top module.

## Test plan
All cases use PULSE_LEN=4, HOLDOFF_LEN=6 unless noted.
- Reset, then `trigger` goes 0→1 and is held for 20 cycles:
  - `pulse` is high for 4 cycles starting 1 cycle after the edge.
  - `busy` stays high through holdoff and REARM, and drops 1 cycle after `trigger` falls.
  - `event_cnt`=1, `overrun`=0.
- `trigger` pulses high for 1 cycle, then pulses again 3 cycles later:
  - The first edge is counted.
  - The second edge arrives during PULSE, so `overrun`=1, `event_cnt`=1 and the pulse width is unchanged at 4.
- `trigger` held high across the reset release: no pulse and `event_cnt`=0 until `trigger` falls and rises again.
- CNT_W=2 with 5 well-spaced events: `event_cnt` reads 1, 2, 3, 3, 3.
- `clr_cnt` asserted in the same cycle as an accepted rise with `event_cnt`=2: the next value is 1. `overrun` is cleared unless an overrun edge occurs in that same cycle.
- `rst_n` pulsed low 2 cycles into a pulse: `pulse`, `busy` and `event_cnt` read 0 immediately, and the state returns to IDLE.
